// File: rtl/sync_debounce.sv
// Synchronizer plus debounce filter for one asynchronous level input.
// Define SYNC_DEBOUNCE_EN to build the debounce FSM; without it o_q simply registers the synchronized level.
module sync_debounce #(
  parameter int N_SYNC    = 2,
  parameter int BW_CNT    = 4,
  parameter int DB_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  if (N_SYNC < 2 || N_SYNC > 4 || DB_CYCLES < 2 || DB_CYCLES > (2**BW_CNT) - 1) begin : g_param_check
    $error("sync_debounce: illegal N_SYNC/BW_CNT/DB_CYCLES combination");
  end

  logic [N_SYNC-1:0] r_sync;
  logic              w_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[N_SYNC-2:0], i_d};
  end

  assign w_s = r_sync[N_SYNC-1];

`ifdef SYNC_DEBOUNCE_EN
  // state      | meaning
  // ST_LO      | stable low, o_q=0
  // ST_WAIT_HI | s went high, counting stable cycles before accepting
  // ST_HI      | stable high, o_q=1
  // ST_WAIT_LO | s went low, counting stable cycles before accepting
  typedef enum logic [1:0] {ST_LO, ST_WAIT_HI, ST_HI, ST_WAIT_LO} state_t;

  localparam logic [BW_CNT-1:0] CNT_ONE  = BW_CNT'(1);
  localparam logic [BW_CNT-1:0] CNT_LAST = BW_CNT'(DB_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [BW_CNT-1:0] r_cnt, w_cnt_nxt;
  logic              r_q, r_rise, r_fall, r_busy;
  logic              w_q_nxt, w_rise_nxt, w_fall_nxt, w_busy_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_LO;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_LO: begin
        if (w_s) begin
          w_state_nxt = ST_WAIT_HI;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_WAIT_HI: begin
        if (!w_s) begin
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = ST_HI;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!w_s) begin
          w_state_nxt = ST_WAIT_LO;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      ST_WAIT_LO: begin
        if (w_s) begin
          w_state_nxt = ST_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= CNT_LAST) begin
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
          w_q_nxt     = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_LO;
        w_cnt_nxt   = '0;
        w_q_nxt     = 1'b0;
      end
    endcase
    // busy is registered alongside the state so it tracks the WAIT states exactly
    w_busy_nxt = (w_state_nxt == ST_WAIT_HI) || (w_state_nxt == ST_WAIT_LO);
  end

  assign o_q    = r_q;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_busy = r_busy;
`else
  logic r_q, r_rise, r_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_q    <= w_s;
      r_rise <= w_s & ~r_q;
      r_fall <= ~w_s & r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
  assign o_busy = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: stimulus queues expected pulses and level/busy samples,
// a negedge monitor pops and compares them as the DUT produces outputs.
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_EN
  localparam int   LAT = 10;
  localparam logic WB  = 1'b1;
`else
  localparam int   LAT = 3;
  localparam logic WB  = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_d;
  logic o_q, o_rise, o_fall, o_busy;

  always #5 i_clk = ~i_clk;

  sync_debounce dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_d),
    .o_q    (o_q),
    .o_rise (o_rise),
    .o_fall (o_fall),
    .o_busy (o_busy)
  );

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic q; logic busy;} pt_t;
  typedef struct {int cyc; logic fall;} ev_t;

  pt_t pt_q[$];
  ev_t ev_q[$];
  pt_t m_pt;
  ev_t m_ev;
  int  n_checks = 0;
  int  n_errors = 0;
  int  t;
  int  r;

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic exp_pt(input int c, input logic q, input logic b);
    pt_q.push_back('{cyc: c, q: q, busy: b});
  endtask

  task automatic exp_ev(input int c, input logic f);
    ev_q.push_back('{cyc: c, fall: f});
  endtask

  // Monitor: pulses are popped when the DUT pulses; level samples when their cycle comes up.
  always @(negedge i_clk) begin
    if (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
      m_ev = ev_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missing_pulse: no %s pulse at cycle %0d (now %0d)",
               m_ev.fall ? "fall" : "rise", m_ev.cyc, cyc);
    end
    if (o_rise || o_fall) begin
      n_checks++;
      if (o_rise && o_fall) begin
        n_errors++;
        $display("FAIL pulse_overlap: rise=1 fall=1 at cycle %0d, required never both", cyc);
      end else if (ev_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse: rise=%0b fall=%0b at cycle %0d, required none", o_rise, o_fall, cyc);
      end else begin
        m_ev = ev_q.pop_front();
        if (m_ev.cyc != cyc || m_ev.fall != o_fall) begin
          n_errors++;
          $display("FAIL pulse: got %s at cycle %0d, required %s at cycle %0d",
                   o_fall ? "fall" : "rise", cyc, m_ev.fall ? "fall" : "rise", m_ev.cyc);
        end
      end
    end
    if (pt_q.size() > 0 && pt_q[0].cyc <= cyc) begin
      m_pt = pt_q.pop_front();
      n_checks++;
      if (m_pt.cyc != cyc || o_q !== m_pt.q || o_busy !== m_pt.busy) begin
        n_errors++;
        $display("FAIL level: cycle %0d got q=%0b busy=%0b, required q=%0b busy=%0b at cycle %0d",
                 cyc, o_q, o_busy, m_pt.q, m_pt.busy, m_pt.cyc);
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_d   = 1'b0;
    step(1);

    // Scenario 1: reset held with i_d high
    t = cyc;
    i_d = 1'b1;
    exp_pt(t + 1, 1'b0, 1'b0);
    exp_pt(t + 2, 1'b0, 1'b0);
    exp_pt(t + 3, 1'b0, 1'b0);
    step(3);
    i_d   = 1'b0;
    i_rst = 1'b0;
    step(6);

    // Scenario 2: clean rising edge, then clean falling edge
    t = cyc;
    i_d = 1'b1;
`ifdef SYNC_DEBOUNCE_EN
    exp_pt(t + 2, 1'b0, 1'b0);
`endif
    exp_pt(t + LAT - 1, 1'b0, WB);
    exp_pt(t + LAT, 1'b1, 1'b0);
    exp_ev(t + LAT, 1'b0);
    step(14);
    t = cyc;
    i_d = 1'b0;
    exp_pt(t + LAT - 1, 1'b1, WB);
    exp_pt(t + LAT, 1'b0, 1'b0);
    exp_ev(t + LAT, 1'b1);
    step(14);

    // Scenario 3: 4-cycle glitch
    t = cyc;
    i_d = 1'b1;
`ifdef SYNC_DEBOUNCE_EN
    exp_pt(t + 2, 1'b0, 1'b0);
    exp_pt(t + 3, 1'b0, 1'b1);
    exp_pt(t + 6, 1'b0, 1'b1);
    exp_pt(t + 7, 1'b0, 1'b0);
`else
    exp_pt(t + 3, 1'b1, 1'b0);
    exp_ev(t + 3, 1'b0);
    exp_pt(t + 7, 1'b0, 1'b0);
    exp_ev(t + 7, 1'b1);
`endif
    step(4);
    i_d = 1'b0;
    step(12);

    // Scenario 4a: held for DB_CYCLES-1 cycles
    t = cyc;
    i_d = 1'b1;
`ifdef SYNC_DEBOUNCE_EN
    exp_pt(t + 3, 1'b0, 1'b1);
    exp_pt(t + 9, 1'b0, 1'b1);
    exp_pt(t + 10, 1'b0, 1'b0);
`else
    exp_pt(t + 3, 1'b1, 1'b0);
    exp_ev(t + 3, 1'b0);
    exp_pt(t + 10, 1'b0, 1'b0);
    exp_ev(t + 10, 1'b1);
`endif
    step(7);
    i_d = 1'b0;
    step(10);

    // Scenario 4b: held for DB_CYCLES cycles, then low held
    t = cyc;
    i_d = 1'b1;
`ifdef SYNC_DEBOUNCE_EN
    exp_pt(t + 9, 1'b0, 1'b1);
    exp_pt(t + 10, 1'b1, 1'b0);
    exp_ev(t + 10, 1'b0);
    exp_pt(t + 11, 1'b1, 1'b1);
    exp_pt(t + 17, 1'b1, 1'b1);
    exp_pt(t + 18, 1'b0, 1'b0);
    exp_ev(t + 18, 1'b1);
`else
    exp_pt(t + 3, 1'b1, 1'b0);
    exp_ev(t + 3, 1'b0);
    exp_pt(t + 11, 1'b0, 1'b0);
    exp_ev(t + 11, 1'b1);
`endif
    step(8);
    i_d = 1'b0;
    step(14);

    // Scenario 5: reset mid-WAIT with i_d held high through and after reset
    t = cyc;
    r = t + 9;
    i_d = 1'b1;
`ifdef SYNC_DEBOUNCE_EN
    exp_pt(t + 3, 1'b0, 1'b1);
    exp_pt(t + 7, 1'b0, 1'b1);
    exp_pt(t + 8, 1'b0, 1'b0);
    exp_pt(r + 2, 1'b0, 1'b0);
    exp_pt(r + 3, 1'b0, 1'b1);
    exp_pt(r + 9, 1'b0, 1'b1);
    exp_pt(r + 10, 1'b1, 1'b0);
    exp_ev(r + 10, 1'b0);
`else
    exp_pt(t + 3, 1'b1, 1'b0);
    exp_ev(t + 3, 1'b0);
    exp_pt(t + 8, 1'b0, 1'b0);
    exp_pt(r + 2, 1'b0, 1'b0);
    exp_pt(r + 3, 1'b1, 1'b0);
    exp_ev(r + 3, 1'b0);
`endif
    step(7);
    i_rst = 1'b1;
    step(2);
    i_rst = 1'b0;
    step(14);

    t = cyc;
    i_d = 1'b0;
    exp_pt(t + LAT, 1'b0, 1'b0);
    exp_ev(t + LAT, 1'b1);
    step(14);

    n_checks++;
    if (ev_q.size() != 0 || pt_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d pulses and %0d samples still pending, required 0", ev_q.size(), pt_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high, with ports named i_clk and i_rst.
REQ-002 Parameter N_SYNC SHALL default to 2 and set the number of synchronizer flops; legal values are 2..4.
REQ-003 Parameter BW_CNT SHALL default to 4 and set the debounce counter width in bits.
REQ-004 Parameter DB_CYCLES SHALL default to 8 and set the stable cycles required to accept a change; legal values are 2..(2^BW_CNT - 1).
REQ-005 Port i_clk SHALL be an input, 1 bit wide, carrying the system clock; all flops update on its rising edge.
REQ-006 Port i_rst SHALL be an input, 1 bit wide, carrying the synchronous active-high reset.
REQ-007 Port i_d SHALL be an input, 1 bit wide, carrying an asynchronous raw level that may change at any time relative to i_clk.
REQ-008 Port o_q SHALL be an output, 1 bit wide, carrying the registered debounced level; it feeds the downstream dff stage.
REQ-009 Port o_rise SHALL be an output, 1 bit wide, carrying a one-cycle pulse when o_q goes 0->1.
REQ-010 Port o_fall SHALL be an output, 1 bit wide, carrying a one-cycle pulse when o_q goes 1->0.
REQ-011 Port o_busy SHALL be an output, 1 bit wide, that is high while a candidate change is being qualified.

Function
REQ-012 i_d SHALL pass through an N_SYNC-deep flop chain; the last stage "s" is the only value the logic after the chain may use.
REQ-013 The FSM SHALL have four states: ST_LO (o_q=0), ST_WAIT_HI, ST_HI (o_q=1) and ST_WAIT_LO.
REQ-014 In ST_LO with s=1, the FSM SHALL go to ST_WAIT_HI with cnt=1; ST_HI with s=0 SHALL behave symmetrically toward ST_WAIT_LO.
REQ-015 In a WAIT state with s equal to the candidate and cnt<DB_CYCLES-1, cnt SHALL increment.
REQ-016 In a WAIT state with s equal to the candidate and cnt=DB_CYCLES-1, the FSM SHALL enter the new stable state, toggle o_q and clear cnt.
REQ-017 In a WAIT state with s reverted to the old level, the FSM SHALL return to the old stable state with cnt=0, and o_q, o_rise and o_fall SHALL stay unchanged (glitch rejected).
REQ-018 If i_d changes before clock edge 1 and then holds, o_q SHALL change at edge N_SYNC+DB_CYCLES (10 with defaults).
REQ-019 o_rise and o_fall SHALL be registered, SHALL assert in the same cycle o_q changes, SHALL last exactly one cycle and SHALL never be high together.
REQ-020 o_busy SHALL be 1 exactly when the state is ST_WAIT_HI or ST_WAIT_LO.
REQ-021 cnt SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-022 A level held stable for exactly DB_CYCLES-1 cycles of s SHALL be rejected.

Reset
REQ-023 While i_rst=1 at a clock edge, all synchronizer flops, o_q, o_rise, o_fall and o_busy SHALL become 0, cnt SHALL become 0 and the state SHALL become ST_LO.
REQ-024 Reset SHALL take priority over i_d and abort any WAIT in progress without emitting a pulse.
REQ-025 After reset is released, a held i_d=1 SHALL produce o_rise per REQ-018, counted from the first edge with i_rst=0.

Configuration
REQ-026 Macro SYNC_DEBOUNCE_EN SHALL control whether the debounce logic is compiled in.
REQ-027 With SYNC_DEBOUNCE_EN defined, the block SHALL behave per REQ-013..REQ-022.
REQ-028 Without SYNC_DEBOUNCE_EN, the FSM and counter SHALL be absent: o_q SHALL register s (latency N_SYNC+1 edges), o_busy SHALL be tied to 0, and o_rise/o_fall SHALL still pulse on each o_q change.

Verification
REQ-029 The bench SHALL use a 100 MHz clock (10 ns period) for all scenarios below.
REQ-030 Scenario 1: i_rst=1 for 3 cycles with i_d=1 -> o_q=0, o_rise=0, o_fall=0 and o_busy=0 throughout reset.
REQ-031 Scenario 2: after reset, i_d 0->1 held -> o_busy high from edge 3, o_q=1 and a single o_rise pulse at edge 10, o_busy low at edge 10.
REQ-032 Scenario 3: i_d high for 4 cycles then low -> o_busy pulses, and o_q, o_rise and o_fall all stay 0.
REQ-033 Scenario 4: i_d held high for exactly 7 then 8 synchronized cycles -> first rejected, second accepted with one o_rise; then i_d low held -> one o_fall 10 edges later.
REQ-034 Scenario 5: i_rst asserted mid-WAIT (cnt=5) -> o_q=0, cnt=0 and no pulse; without SYNC_DEBOUNCE_EN, i_d 0->1 -> o_q=1 and o_rise at edge 3.
